// File: rtl/arpas_pkg.sv
// Shared defaults and helpers for the arpas demultiplexing sequencer.
package arpas_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 1;

  function automatic int sel_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/arpas_onehot_dec.sv
// Selector to one-hot decoder; also produces enable-qualified write strobes.
module arpas_onehot_dec #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [SW-1:0] sel_i,
  input  logic          en_i,
  output logic [N-1:0]  oh_o,
  output logic [N-1:0]  we_o
);

  always_comb begin
    oh_o        = '0;
    oh_o[sel_i] = 1'b1;
  end

  assign we_o = oh_o & {N{en_i}};

endmodule

// File: rtl/arpas_demux_seq.sv
// Steers a valid/ready stream into per-channel holding registers chosen by a
// selector that advances on inc edges, on accepted beats, or by direct load.
module arpas_demux_seq
  import arpas_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  parameter  int W    = W_DEF,
  localparam int SW   = sel_width(N_CH)
) (
  input  logic              c,
  input  logic              r_n,
  input  logic [W-1:0]      sig,
  input  logic              sig_valid,
  output logic              sig_ready,
  input  logic              inc,
  input  logic              auto_adv,
  input  logic              load,
  input  logic [SW-1:0]     load_sel,
  output logic [N_CH*W-1:0] out,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [SW-1:0]     sel,
  output logic [N_CH-1:0]   sel_oh,
  output logic              wrap
);

  logic [SW-1:0]   sel_q, sel_d;
  logic            wrap_q, wrap_d;
  logic            inc_q;
  logic [N_CH-1:0] vld_q;
  logic [N_CH-1:0] we;
  logic            accept;
  logic            inc_edge;
  logic            adv;

  // Gating with r_n keeps the stream stalled while reset is held.
  assign sig_ready = r_n & (~vld_q[sel_q] | out_ready[sel_q]);
  assign accept    = sig_valid & sig_ready;
  assign inc_edge  = inc & ~inc_q;
  assign adv       = inc_edge | (auto_adv & accept);

  arpas_onehot_dec #(.N(N_CH), .SW(SW)) u_dec (
    .sel_i (sel_q),
    .en_i  (accept),
    .oh_o  (sel_oh),
    .we_o  (we)
  );

  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (load) begin
      sel_d = load_sel;
    end else if (adv) begin
      sel_d  = sel_q + 1'b1;
      wrap_d = (sel_q == {SW{1'b1}});
    end
  end

  // inc_q resets high so an inc held across reset release is not an edge.
  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      sel_q  <= '0;
      wrap_q <= 1'b0;
      inc_q  <= 1'b1;
    end else begin
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
      inc_q  <= inc;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [W-1:0] dat_q;
    logic         v_q;

    always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
        dat_q <= '0;
        v_q   <= 1'b0;
      end else if (we[k]) begin
        dat_q <= sig;
        v_q   <= 1'b1;
      end else if (out_ready[k]) begin
        v_q   <= 1'b0;
      end
    end

    assign out[k*W +: W] = dat_q;
    assign vld_q[k]      = v_q;
  end

  assign out_valid = vld_q;
  assign sel       = sel_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_arpas_demux_seq.sv
// Directed bench: a 4x8 instance for the main scenarios, an 8x1 instance for the wide-selector stream.
module tb_arpas_demux_seq;

  logic clk = 1'b0;
  logic r_n;
  always #5 clk = ~clk;

  logic [7:0]  a_sig;
  logic        a_valid, a_ready, a_inc, a_auto, a_load, a_wrap;
  logic [1:0]  a_lsel, a_sel;
  logic [31:0] a_out;
  logic [3:0]  a_ovld, a_ordy, a_oh;

  logic [0:0]  b_sig;
  logic        b_valid, b_ready, b_inc, b_auto, b_load, b_wrap;
  logic [2:0]  b_lsel, b_sel;
  logic [7:0]  b_out, b_ovld, b_ordy, b_oh;

  int checks = 0;
  int errors = 0;

  arpas_demux_seq #(.N_CH(4), .W(8)) dut_a (
    .c(clk), .r_n(r_n), .sig(a_sig), .sig_valid(a_valid), .sig_ready(a_ready),
    .inc(a_inc), .auto_adv(a_auto), .load(a_load), .load_sel(a_lsel),
    .out(a_out), .out_valid(a_ovld), .out_ready(a_ordy),
    .sel(a_sel), .sel_oh(a_oh), .wrap(a_wrap)
  );

  arpas_demux_seq #(.N_CH(8), .W(1)) dut_b (
    .c(clk), .r_n(r_n), .sig(b_sig), .sig_valid(b_valid), .sig_ready(b_ready),
    .inc(b_inc), .auto_adv(b_auto), .load(b_load), .load_sel(b_lsel),
    .out(b_out), .out_valid(b_ovld), .out_ready(b_ordy),
    .sel(b_sel), .sel_oh(b_oh), .wrap(b_wrap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] pat;
    int ch;

    r_n = 1'b0;
    a_sig = '0; a_valid = 0; a_inc = 0; a_auto = 0; a_load = 0; a_lsel = '0; a_ordy = '0;
    b_sig = '0; b_valid = 0; b_inc = 0; b_auto = 0; b_load = 0; b_lsel = '0; b_ordy = '0;
    #1;
    chk("rst_sel", a_sel, 2'd0);
    chk("rst_ovld", a_ovld, 4'h0);
    chk("rst_out", a_out, 32'h0);
    chk("rst_wrap", a_wrap, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_oh", a_oh, 4'b0001);
    tick(); tick();
    r_n = 1'b1;
    tick();

    // first beat lands in channel 0, second stalls
    a_sig = 8'hA5; a_valid = 1;
    #1 chk("b1_ready", a_ready, 1'b1);
    tick();
    chk("b1_out0", a_out[7:0], 8'hA5);
    chk("b1_ovld", a_ovld, 4'b0001);
    chk("b2_stall", a_ready, 1'b0);
    a_sig = 8'h5A;
    tick();
    chk("b2_hold", a_out[7:0], 8'hA5);
    a_valid = 0; a_ordy = 4'b0001;
    tick();
    chk("drain0", a_ovld, 4'b0000);
    a_ordy = 4'b0000;

    // channel 1 simultaneous drain and refill
    a_load = 1; a_lsel = 2'd1;
    tick();
    a_load = 0;
    chk("ld1_sel", a_sel, 2'd1);
    chk("ld1_oh", a_oh, 4'b0010);
    a_sig = 8'h11; a_valid = 1;
    tick();
    chk("c1_fill", a_out[15:8], 8'h11);
    a_sig = 8'h22; a_ordy = 4'b0010;
    #1 chk("c1_ready", a_ready, 1'b1);
    tick();
    chk("c1_vld", a_ovld, 4'b0010);
    chk("c1_data", a_out[15:8], 8'h22);
    chk("c0_retain", a_out[7:0], 8'hA5);
    a_valid = 0; a_ordy = 4'b1111;
    tick();

    // auto-advance stream 01..05 over channels 0,1,2,3,0
    a_load = 1; a_lsel = 2'd0;
    tick();
    a_load = 0;
    chk("ld0_wrap", a_wrap, 1'b0);
    a_auto = 1; a_valid = 1;
    a_sig = 8'h01; tick();
    chk("s1_d", a_out[7:0], 8'h01);   chk("s1_v", a_ovld, 4'b0001); chk("s1_sel", a_sel, 2'd1); chk("s1_w", a_wrap, 1'b0);
    a_sig = 8'h02; tick();
    chk("s2_d", a_out[15:8], 8'h02);  chk("s2_v", a_ovld, 4'b0010); chk("s2_sel", a_sel, 2'd2); chk("s2_w", a_wrap, 1'b0);
    a_sig = 8'h03; tick();
    chk("s3_d", a_out[23:16], 8'h03); chk("s3_v", a_ovld, 4'b0100); chk("s3_sel", a_sel, 2'd3); chk("s3_w", a_wrap, 1'b0);
    a_sig = 8'h04; tick();
    chk("s4_d", a_out[31:24], 8'h04); chk("s4_v", a_ovld, 4'b1000); chk("s4_sel", a_sel, 2'd0); chk("s4_w", a_wrap, 1'b1);
    a_sig = 8'h05; tick();
    chk("s5_d", a_out[7:0], 8'h05);   chk("s5_v", a_ovld, 4'b0001); chk("s5_sel", a_sel, 2'd1); chk("s5_w", a_wrap, 1'b0);
    a_valid = 0; a_auto = 0;
    tick();

    // inc pulses: five cycles high, two low, three times
    a_load = 1; a_lsel = 2'd0;
    tick();
    a_load = 0;
    for (int r = 1; r <= 3; r++) begin
      a_inc = 1;
      repeat (5) tick();
      a_inc = 0;
      repeat (2) tick();
      chk("inc_sel", a_sel, 64'(r));
    end
    chk("inc_nowrap", a_wrap, 1'b0);

    // inc held high through reset release
    a_inc = 1; r_n = 0;
    #1 chk("rst_inc_sel", a_sel, 2'd0);
    tick(); tick();
    r_n = 1;
    tick(); tick();
    chk("rel_inc_sel", a_sel, 2'd0);
    a_inc = 0;
    tick();

    // load beats inc edge and auto-advance; beat goes to the old selector
    a_load = 1; a_lsel = 2'd3;
    tick();
    chk("ld3_sel", a_sel, 2'd3);
    a_inc = 1; a_lsel = 2'd2; a_sig = 8'h77; a_valid = 1; a_auto = 1;
    #1 chk("ld_ready", a_ready, 1'b1);
    tick();
    chk("ld_data", a_out[31:24], 8'h77);
    chk("ld_ovld", a_ovld, 4'b1000);
    chk("ld_sel", a_sel, 2'd2);
    chk("ld_oh", a_oh, 4'b0100);
    chk("ld_nowrap", a_wrap, 1'b0);
    a_load = 0; a_valid = 0;
    tick();
    chk("inc_level_hold", a_sel, 2'd2);

    // inc edge and auto-advance together advance once
    a_inc = 0;
    tick();
    a_inc = 1; a_sig = 8'h88; a_valid = 1; a_ordy = 4'b1111;
    tick();
    chk("once_sel", a_sel, 2'd3);
    chk("once_data", a_out[23:16], 8'h88);
    a_inc = 0; a_valid = 0;
    tick();

    // fill all channels, then reset mid-stream
    a_ordy = 4'b0000; a_valid = 1;
    a_sig = 8'hC0; tick();
    a_sig = 8'hC1; tick();
    a_sig = 8'hC2; tick();
    a_sig = 8'hC3; tick();
    chk("full_ovld", a_ovld, 4'b1111);
    chk("full_d3", a_out[31:24], 8'hC0);
    chk("full_sel", a_sel, 2'd3);
    #2 r_n = 0;
    #1;
    chk("mrst_out", a_out, 32'h0);
    chk("mrst_ovld", a_ovld, 4'h0);
    chk("mrst_sel", a_sel, 2'd0);
    chk("mrst_ready", a_ready, 1'b0);
    tick();
    chk("mrst_noacc", a_ovld, 4'h0);
    a_valid = 0; a_auto = 0;
    r_n = 1;
    tick();

    // eight-channel single-bit stream
    pat = 9'b1_0010_1101;
    b_auto = 1; b_ordy = 8'hFF; b_valid = 1;
    for (int i = 0; i < 9; i++) begin
      ch = i % 8;
      b_sig = pat[i];
      tick();
      chk("b_data", b_out[ch], pat[i]);
      chk("b_ovld", b_ovld, 64'(8'(1) << ch));
      chk("b_sel", b_sel, 64'((i + 1) % 8));
      chk("b_oh", b_oh, 64'(8'(1) << ((i + 1) % 8)));
      chk("b_wrap", b_wrap, (i == 7) ? 64'd1 : 64'd0);
    end
    b_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arpas_demux_seq.md
ARPAS_DEMUX_SEQ -- requirements
Module: arpas_demux_seq

Interface
REQ-001 Parameter N_CH, default 4, channel count; SHALL be a power of two, 2..64.
REQ-002 Parameter W, default 1, data width per channel.
REQ-003 Parameter SW, default $clog2(N_CH), selector width; SHALL be derived, not overridden.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 c  input  1  clock; all state on rising edge.
REQ-006 r_n  input  1  asynchronous active-low reset.
REQ-007 sig  input  W  data to distribute.
REQ-008 sig_valid  input  1  sig carries a beat this cycle.
REQ-009 sig_ready  output  1  beat accepted when sig_valid & sig_ready.
REQ-010 inc  input  1  level; each rising edge advances the selector by one.
REQ-011 auto_adv  input  1  mode: advance the selector after every accepted beat.
REQ-012 load  input  1  load selector from load_sel this cycle.
REQ-013 load_sel  input  SW  selector value to load.
REQ-014 out  output  N_CH*W  channel k data at bits [k*W +: W], registered.
REQ-015 out_valid  output  N_CH  per-channel holding register full.
REQ-016 out_ready  input  N_CH  per-channel consumer accepts.
REQ-017 sel  output  SW  current selector.
REQ-018 sel_oh  output  N_CH  one-hot decode of sel.
REQ-019 wrap  output  1  one-cycle pulse when selector increments N_CH-1 -> 0.

Function
REQ-020 Each channel SHALL hold one W-bit register plus valid bit; out/out_valid come straight from flops.
REQ-021 sig_ready SHALL equal ~out_valid[sel] | out_ready[sel] (combinational, same-cycle pass-through of drain).
REQ-022 Accepted beat SHALL be written into channel sel (pre-update value) and appear on out/out_valid one cycle later.
REQ-023 Channel k valid SHALL clear on out_valid[k] & out_ready[k] unless refilled the same cycle; simultaneous drain+fill keeps valid=1 with new data.
REQ-024 Channels other than sel SHALL never be written; their out holds value while valid=0 is don't-care but SHALL retain last data.
REQ-025 inc edge detect: inc_q registers inc; edge = inc & ~inc_q.
REQ-026 Selector next-state priority: load -> load_sel; else (edge | (auto_adv & accepted beat)) -> sel+1 mod N_CH; else hold.
REQ-027 Edge and auto-advance in the same cycle SHALL advance exactly once.
REQ-028 wrap SHALL pulse (registered, aligned with sel changing to 0) only on increment from N_CH-1; load to 0 SHALL NOT pulse wrap.
REQ-029 New sel SHALL affect routing and sig_ready from the following cycle.
REQ-030 sel_oh SHALL be exactly one-hot at all times after reset.

Reset
REQ-031 On r_n low, asynchronously: sel=0, out_valid=0, out=0, wrap=0, inc_q=1 (inc held high across reset release SHALL NOT advance).
REQ-032 Reset mid-transfer SHALL discard all held beats; no beat accepted in the cycle r_n is low.
REQ-033 sig_ready SHALL be 0 while r_n is low.

Structure
REQ-034 Package arpas_pkg SHALL hold default N_CH/W constants and the sel-width function; no block-local typedefs.
REQ-035 One sub-module arpas_onehot_dec (SW -> N_CH one-hot decoder, parametrised) SHALL generate sel_oh and write enables.
REQ-036 Per-channel registers SHALL be a generate loop; no latches; single clock domain.

Verification
REQ-037 N_CH=4,W=8: reset, sig=0xA5 valid, all out_ready=0 -> out[7:0]=0xA5, out_valid=0001 next cycle; second beat stalls (sig_ready=0).
REQ-038 auto_adv=1, out_ready=all 1, stream 0x01..0x05 -> channels 0,1,2,3,0 receive in order; wrap pulses once as sel 3->0.
REQ-039 inc held high 5 cycles then low, repeated 3 times -> sel=3; inc high through reset release -> sel stays 0.
REQ-040 load=1,load_sel=2 with inc edge and accepted beat same cycle -> beat lands channel current sel, sel=2 next, no wrap.
REQ-041 Channel 1 full with out_ready[1]=1 and new beat same cycle -> sig_ready=1, out_valid[1] stays 1, data replaced.
REQ-042 r_n asserted mid-stream with out_valid=1111 -> all outputs 0 immediately, sel=0; N_CH=8,W=1 rerun of REQ-038 passes.
